// File: rtl/multichannel_wr_arbiter_rr.sv
// ============================================================================
// Module   : multichannel_wr_arbiter_rr
// Brief    : N-channel round-robin DDR write arbiter with enable mask and watchdog
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multichannel_wr_arbiter_rr #(
    parameter int CH_NUM      = 4,
    parameter int AXI_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 30,
    parameter int LEN_WIDTH   = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CH_NUM-1:0]               ch_en,
    input  logic [CH_NUM-1:0]               wr_req,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]    wr_addr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]     wr_len,
    input  logic [CH_NUM*AXI_WIDTH-1:0]     wr_data,
    output logic [CH_NUM-1:0]               wr_grant,
    output logic [CH_W-1:0]                 grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    input  logic                            wr_done,
    output logic                            axi_wr_start,
    output logic [ADDR_WIDTH-1:0]           axi_wr_addr,
    output logic [LEN_WIDTH-1:0]            axi_wr_len,
    output logic [AXI_WIDTH-1:0]            axi_wr_data
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CH_W-1:0]  c_PTR_RST = CH_W'(CH_NUM - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [1:0]            r_state;
    logic [CH_W-1:0]       r_ptr;
    logic [CH_W-1:0]       r_grant_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [CNT_W-1:0]      r_cnt;

    logic [CH_NUM-1:0]     w_req_m;
    logic                  w_any_req;
    logic [CH_W-1:0]       w_win;
    logic                  w_found;
    logic                  w_rearb;
    logic                  w_timeout;
    logic [CH_NUM-1:0]     w_grant;
    int                    w_idx;

    assign w_req_m   = wr_req & ch_en;
    assign w_any_req = |w_req_m;

    // Search starts one past the last grant so the previous winner is tried last.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= CH_NUM; k++) begin
            w_idx = (int'(r_ptr) + k) % CH_NUM;
            if (!w_found && w_req_m[w_idx]) begin
                w_found = 1'b1;
                w_win   = CH_W'(w_idx);
            end
        end
    end

    // A done in the expiry cycle counts as normal completion.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_state == S_BUSY)
                       && (r_cnt == c_TIMEOUT) && !wr_done;

    assign w_rearb = w_any_req &&
                     ((r_state == S_IDLE) || ((r_state == S_BUSY) && wr_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= c_PTR_RST;
            r_grant_id <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_rearb) begin
                r_ptr      <= w_win;
                r_grant_id <= w_win;
                r_addr     <= wr_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                r_len      <= wr_len[int'(w_win)*LEN_WIDTH +: LEN_WIDTH];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_state <= S_BUSY;
                    r_cnt   <= '0;
                end
                S_BUSY: begin
                    if (wr_done) begin
                        r_state <= w_any_req ? S_GRANT : S_IDLE;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_grant = '0;
        if (r_state != S_IDLE) begin
            w_grant[r_grant_id] = 1'b1;
        end
    end

    assign wr_grant     = w_grant;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != S_IDLE);
    assign timeout_err  = w_timeout;
    assign axi_wr_start = (r_state == S_GRANT) && !rst;
    assign axi_wr_addr  = r_addr;
    assign axi_wr_len   = r_len;
    assign axi_wr_data  = (r_state != S_IDLE)
                          ? wr_data[int'(r_grant_id)*AXI_WIDTH +: AXI_WIDTH]
                          : '0;

endmodule

`default_nettype wire

// File: tb/tb_multichannel_wr_arbiter_rr.sv
// ============================================================================
// Module   : tb_multichannel_wr_arbiter_rr
// Brief    : Directed self-checking bench for multichannel_wr_arbiter_rr
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multichannel_wr_arbiter_rr;

    localparam int CH  = 4;
    localparam int AW  = 30;
    localparam int LW  = 8;
    localparam int DW  = 64;
    localparam int TO  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     ch_en;
    logic [CH-1:0]     wr_req;
    logic [CH*AW-1:0]  wr_addr;
    logic [CH*LW-1:0]  wr_len;
    logic [CH*DW-1:0]  wr_data;
    logic [CH-1:0]     wr_grant;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;
    logic              wr_done;
    logic              axi_wr_start;
    logic [AW-1:0]     axi_wr_addr;
    logic [LW-1:0]     axi_wr_len;
    logic [DW-1:0]     axi_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    multichannel_wr_arbiter_rr #(
        .CH_NUM(CH), .AXI_WIDTH(DW), .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW), .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
        .wr_grant(wr_grant), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .wr_done(wr_done),
        .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr),
        .axi_wr_len(axi_wr_len), .axi_wr_data(axi_wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int ch);
        return AW'(32'h0001_0000 + ch * 32'h100);
    endfunction

    function automatic logic [LW-1:0] len_of(input int ch);
        return LW'(8'h10 + ch);
    endfunction

    function automatic logic [DW-1:0] data_of(input int ch);
        return 64'hDA7A_0000_0000_0000 | 64'(ch);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entry: cycle holding the start pulse of channel ch; done 5 cycles later.
    task automatic burst(input int ch, input bit last);
        chk("start_pulse", 64'(axi_wr_start), 64'd1);
        chk("grant_id", 64'(grant_id), 64'(ch));
        chk("wr_grant", 64'(wr_grant), 64'(4'b0001 << ch));
        chk("axi_addr", 64'(axi_wr_addr), 64'(addr_of(ch)));
        chk("axi_len", 64'(axi_wr_len), 64'(len_of(ch)));
        chk("axi_data", axi_wr_data, data_of(ch));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("start_low_in_busy", 64'(axi_wr_start), 64'd0);
            chk("busy_held", 64'(busy), 64'd1);
        end
        if (last) wr_req = '0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        ch_en   = '0;
        wr_req  = '0;
        wr_done = 1'b0;
        for (int i = 0; i < CH; i++) begin
            wr_addr[i*AW +: AW] = addr_of(i);
            wr_len[i*LW +: LW]  = len_of(i);
            wr_data[i*DW +: DW] = data_of(i);
        end
        tick();
        tick();
        rst = 1'b0;

        chk("rst_grant", 64'(wr_grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_start", 64'(axi_wr_start), 64'd0);
        chk("rst_addr", 64'(axi_wr_addr), 64'd0);
        chk("rst_len", 64'(axi_wr_len), 64'd0);
        chk("rst_tmo", 64'(timeout_err), 64'd0);
        chk("rst_data", axi_wr_data, 64'd0);

        // Three requesters, rotation 0,1,3
        ch_en  = 4'hF;
        wr_req = 4'b1011;
        tick();
        burst(0, 0); burst(1, 0); burst(3, 0);
        burst(0, 0); burst(1, 0); burst(3, 1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_grant", 64'(wr_grant), 64'd0);
        chk("idle_gid_held", 64'(grant_id), 64'd3);

        // Lone requester re-granted back to back
        wr_req = 4'b0100;
        tick();
        burst(2, 0); burst(2, 0); burst(2, 1);
        chk("single_idle", 64'(busy), 64'd0);

        // Inputs of the granted channel change during the burst
        wr_req = 4'b0010;
        tick();
        chk("c1_start", 64'(axi_wr_start), 64'd1);
        chk("c1_addr", 64'(axi_wr_addr), 64'(addr_of(1)));
        tick();
        wr_req = '0;
        wr_addr[1*AW +: AW] = 30'h3ABC_DEF;
        wr_len[1*LW +: LW]  = 8'hEE;
        wr_data[1*DW +: DW] = 64'h1111_2222_3333_4444;
        #1;
        chk("c1_data_track1", axi_wr_data, 64'h1111_2222_3333_4444);
        tick();
        chk("c1_addr_hold", 64'(axi_wr_addr), 64'(addr_of(1)));
        chk("c1_len_hold", 64'(axi_wr_len), 64'(len_of(1)));
        chk("c1_grant_hold", 64'(wr_grant), 64'b0010);
        wr_data[1*DW +: DW] = 64'h5555_6666_7777_8888;
        #1;
        chk("c1_data_track2", axi_wr_data, 64'h5555_6666_7777_8888);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("c1_done_idle", 64'(busy), 64'd0);
        wr_addr[1*AW +: AW] = addr_of(1);
        wr_len[1*LW +: LW]  = len_of(1);
        wr_data[1*DW +: DW] = data_of(1);

        // Channel 1 masked; pointer sits at 1 so rotation is 2,3,0,2
        ch_en  = 4'b1101;
        wr_req = 4'hF;
        tick();
        burst(2, 0); burst(3, 0); burst(0, 0); burst(2, 1);

        // Watchdog expiry on channel 3 (pointer at 2)
        ch_en  = 4'hF;
        wr_req = 4'b1001;
        tick();
        chk("wd_gid", 64'(grant_id), 64'd3);
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("wd_quiet", 64'(timeout_err), 64'd0);
            tick();
        end
        chk("wd_fire", 64'(timeout_err), 64'd1);
        chk("wd_fire_busy", 64'(busy), 64'd1);
        tick();
        chk("wd_idle", 64'(busy), 64'd0);
        chk("wd_pulse_end", 64'(timeout_err), 64'd0);
        tick();
        chk("wd_next_start", 64'(axi_wr_start), 64'd1);
        chk("wd_next_gid", 64'(grant_id), 64'd0);

        // Done coincides with expiry: completes normally and re-arbitrates to 3
        wr_req = 4'b1000;
        tick();
        for (int i = 0; i < TO; i++) tick();
        wr_done = 1'b1;
        #1;
        chk("wd_done_wins", 64'(timeout_err), 64'd0);
        tick();
        wr_done = 1'b0;
        chk("wd_done_start", 64'(axi_wr_start), 64'd1);
        chk("wd_done_gid", 64'(grant_id), 64'd3);

        // Reset pulse mid-burst on channel 3
        wr_req = 4'b1001;
        tick();
        tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_no_start", 64'(axi_wr_start), 64'd0);
        tick();
        rst = 1'b0;
        chk("mid_rst_grant", 64'(wr_grant), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_gid", 64'(grant_id), 64'd0);
        chk("mid_rst_addr", 64'(axi_wr_addr), 64'd0);
        chk("mid_rst_len", 64'(axi_wr_len), 64'd0);
        chk("mid_rst_start", 64'(axi_wr_start), 64'd0);
        tick();
        chk("post_rst_start", 64'(axi_wr_start), 64'd1);
        chk("post_rst_gid", 64'(grant_id), 64'd0);
        chk("post_rst_addr", 64'(axi_wr_addr), 64'(addr_of(0)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
